branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor_if.sv | 25 ++
 rtl/branch_predictor.sv | 79 +++++++
 tb/tb_branch_predictor.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Fetch-side prediction and execute-side resolution signals shared between
// the pipeline (master) and the branch predictor (slave).
interface branch_predictor_if;
  logic [31:0] IF_PC;
  logic        PredTaken;
  logic [31:0] PredTarget;
  logic        PredHit;
  logic        EX_Valid;
  logic [31:0] EX_PC;
  logic        EX_Taken;
  logic [31:0] EX_Target;
  logic        EX_PredTaken;
  logic        Mispredict;
  logic [15:0] MispredCnt;

  modport master (
    output IF_PC, EX_Valid, EX_PC, EX_Taken, EX_Target, EX_PredTaken,
    input  PredTaken, PredTarget, PredHit, Mispredict, MispredCnt
  );

  modport slave (
    input  IF_PC, EX_Valid, EX_PC, EX_Taken, EX_Target, EX_PredTaken,
    output PredTaken, PredTarget, PredHit, Mispredict, MispredCnt
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: tagged target table with 2-bit saturating
// direction counters, zero-latency lookup and a saturating mispredict counter.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int IDXW    = 4
) (
  input logic               clk,
  input logic               reset,
  branch_predictor_if.slave bp
);
  localparam int TAGW = 32 - IDXW - 2;

  logic            valid_q  [ENTRIES];
  logic [TAGW-1:0] tag_q    [ENTRIES];
  logic [31:0]     target_q [ENTRIES];
  logic [1:0]      ctr_q    [ENTRIES];
  logic [15:0]     mispred_cnt_q;

  logic [IDXW-1:0] if_idx;
  logic [TAGW-1:0] if_tag;
  logic            if_hit;
  logic [IDXW-1:0] ex_idx;
  logic [TAGW-1:0] ex_tag;
  logic            ex_hit;
  logic            mispredict;
  logic            unused_pc_lsbs;

  assign if_idx = bp.IF_PC[IDXW+1:2];
  assign if_tag = bp.IF_PC[31:IDXW+2];
  assign ex_idx = bp.EX_PC[IDXW+1:2];
  assign ex_tag = bp.EX_PC[31:IDXW+2];
  assign unused_pc_lsbs = ^{bp.IF_PC[1:0], bp.EX_PC[1:0]};

  // Lookup reads the registered table only, so a same-cycle update is not seen.
  assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  assign bp.PredHit    = if_hit;
  assign bp.PredTaken  = if_hit && ctr_q[if_idx][1];
  assign bp.PredTarget = (if_hit && ctr_q[if_idx][1]) ? target_q[if_idx]
                                                      : bp.IF_PC + 32'd4;

  assign mispredict    = bp.EX_Valid && (bp.EX_PredTaken != bp.EX_Taken);
  assign bp.Mispredict = mispredict;
  assign bp.MispredCnt = mispred_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
      mispred_cnt_q <= '0;
    end else begin
      if (mispredict && (mispred_cnt_q != 16'hFFFF))
        mispred_cnt_q <= mispred_cnt_q + 16'd1;

      if (bp.EX_Valid) begin
        if (ex_hit) begin
          if (bp.EX_Taken) begin
            if (ctr_q[ex_idx] != 2'b11)
              ctr_q[ex_idx] <= ctr_q[ex_idx] + 2'd1;
            target_q[ex_idx] <= bp.EX_Target;
          end else if (ctr_q[ex_idx] != 2'b00) begin
            ctr_q[ex_idx] <= ctr_q[ex_idx] - 2'd1;
          end
        end else if (bp.EX_Taken) begin
          // Taken miss evicts whatever aliased into this slot.
          valid_q[ex_idx]  <= 1'b1;
          tag_q[ex_idx]    <= ex_tag;
          target_q[ex_idx] <= bp.EX_Target;
          ctr_q[ex_idx]    <= 2'b10;
        end
      end
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Randomized and directed bench for branch_predictor against an array-based
// behavioural model of the prediction table.
module tb_branch_predictor;
  localparam int ENTRIES = 16;
  localparam int IDXW    = 4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  branch_predictor_if bp ();

  branch_predictor #(.ENTRIES(ENTRIES), .IDXW(IDXW)) dut (
    .clk   (clk),
    .reset (reset),
    .bp    (bp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  int          m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned idx_of(input logic [31:0] pc);
    return (int'(pc) >>> 2) % ENTRIES & (ENTRIES - 1);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return int'(pc >> (IDXW + 2));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
      m_tgt[i]   = 32'h0;
      m_ctr[i]   = 1;
    end
    m_cnt = 0;
  endtask

  task automatic model_predict(input logic [31:0] pc, output logic hit,
                               output logic tkn, output logic [31:0] tgt);
    int unsigned i;
    i   = idx_of(pc);
    hit = m_valid[i] && (m_tag[i] == tag_of(pc));
    tkn = hit && (m_ctr[i] >= 2);
    tgt = tkn ? m_tgt[i] : pc + 32'd4;
  endtask

  task automatic model_update(input logic rst_n, input logic exv, input logic [31:0] expc,
                              input logic ext, input logic [31:0] extg, input logic expt);
    int unsigned i;
    bit          hit;
    if (!rst_n) begin
      model_clear();
      return;
    end
    if (exv && (expt != ext) && m_cnt < 65535) m_cnt++;
    if (!exv) return;
    i   = idx_of(expc);
    hit = m_valid[i] && (m_tag[i] == tag_of(expc));
    if (hit) begin
      if (ext) begin
        m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
        m_tgt[i] = extg;
      end else begin
        m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
      end
    end else if (ext) begin
      m_valid[i] = 1'b1;
      m_tag[i]   = tag_of(expc);
      m_tgt[i]   = extg;
      m_ctr[i]   = 2;
    end
  endtask

  // Drive one cycle, check outputs against the pre-edge model, then advance both.
  task automatic cycle(input logic [31:0] ifpc, input logic exv, input logic [31:0] expc,
                       input logic ext, input logic [31:0] extg, input logic expt,
                       input logic rst_n);
    logic        h, t;
    logic [31:0] tg;
    bp.IF_PC        = ifpc;
    bp.EX_Valid     = exv;
    bp.EX_PC        = expc;
    bp.EX_Taken     = ext;
    bp.EX_Target    = extg;
    bp.EX_PredTaken = expt;
    reset           = rst_n;
    #1;
    model_predict(ifpc, h, t, tg);
    chk("PredHit", {31'b0, bp.PredHit}, {31'b0, h});
    chk("PredTaken", {31'b0, bp.PredTaken}, {31'b0, t});
    chk("PredTarget", bp.PredTarget, tg);
    chk("Mispredict", {31'b0, bp.Mispredict}, {31'b0, exv && (expt != ext)});
    chk("MispredCnt", {16'b0, bp.MispredCnt}, m_cnt);
    @(posedge clk);
    model_update(rst_n, exv, expc, ext, extg, expt);
    #1;
  endtask

  task automatic probe(input logic [31:0] ifpc);
    bp.IF_PC    = ifpc;
    bp.EX_Valid = 1'b0;
    #1;
  endtask

  task automatic upd(input logic [31:0] expc, input logic ext, input logic [31:0] extg);
    cycle(32'h0, 1'b1, expc, ext, extg, ext, 1'b1);
  endtask

  logic [31:0] pool [8];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_clear();
    reset           = 1'b0;
    bp.IF_PC        = 32'h40;
    bp.EX_Valid     = 1'b0;
    bp.EX_PC        = 32'h0;
    bp.EX_Taken     = 1'b0;
    bp.EX_Target    = 32'h0;
    bp.EX_PredTaken = 1'b0;
    @(posedge clk);
    #1;

    // Updates presented during reset must be discarded.
    cycle(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 1'b0);
    cycle(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 1'b0);

    probe(32'h40);
    chk("rst_hit", {31'b0, bp.PredHit}, 32'd0);
    chk("rst_taken", {31'b0, bp.PredTaken}, 32'd0);
    chk("rst_target", bp.PredTarget, 32'h44);
    chk("rst_cnt", {16'b0, bp.MispredCnt}, 32'd0);

    // Same-cycle read/write on an empty slot: lookup sees the old table.
    cycle(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 1'b1);
    probe(32'h40);
    chk("alloc_hit", {31'b0, bp.PredHit}, 32'd1);
    chk("alloc_taken", {31'b0, bp.PredTaken}, 32'd1);
    chk("alloc_target", bp.PredTarget, 32'h100);

    for (int i = 0; i < 3; i++) upd(32'h40, 1'b1, 32'h100);
    upd(32'h40, 1'b0, 32'h0);
    probe(32'h40);
    chk("sat_taken_10", {31'b0, bp.PredTaken}, 32'd1);
    chk("sat_target_10", bp.PredTarget, 32'h100);
    upd(32'h40, 1'b0, 32'h0);
    upd(32'h40, 1'b0, 32'h0);
    probe(32'h40);
    chk("sat_taken_00", {31'b0, bp.PredTaken}, 32'd0);
    chk("sat_hit_00", {31'b0, bp.PredHit}, 32'd1);
    chk("sat_target_00", bp.PredTarget, 32'h44);
    upd(32'h40, 1'b0, 32'h0);
    upd(32'h40, 1'b1, 32'h200);
    probe(32'h40);
    chk("floor_taken", {31'b0, bp.PredTaken}, 32'd0);

    upd(32'h80, 1'b1, 32'h300);
    probe(32'h40);
    chk("alias_old_hit", {31'b0, bp.PredHit}, 32'd0);
    probe(32'h80);
    chk("alias_new_hit", {31'b0, bp.PredHit}, 32'd1);
    chk("alias_new_target", bp.PredTarget, 32'h300);
    upd(32'hC4, 1'b0, 32'h500);
    probe(32'hC4);
    chk("nt_miss_noalloc", {31'b0, bp.PredHit}, 32'd0);

    pool[0] = 32'h40;        pool[1] = 32'h80;
    pool[2] = 32'h44;        pool[3] = 32'h1000;
    pool[4] = 32'h2040;      pool[5] = 32'hFFFF_FFFC;
    pool[6] = 32'h8000_0048; pool[7] = 32'h0000_0084;
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ipc, epc;
      ipc = pool[$urandom_range(7)] | ($urandom & 32'h3);
      epc = pool[$urandom_range(7)] | ($urandom & 32'h3);
      if ($urandom_range(9) == 0) begin
        ipc = $urandom;
        epc = $urandom;
      end
      cycle(ipc, 1'($urandom), epc, 1'($urandom), $urandom, 1'($urandom),
            ($urandom_range(63) != 0));
    end

    cycle(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int n = 0; n < 65540; n++)
      cycle(32'h40, 1'b1, 32'h1000 + 32'(n[3:0]) * 4, 1'b1, 32'h700, 1'b0, 1'b1);
    probe(32'h40);
    chk("cnt_saturated", {16'b0, bp.MispredCnt}, 32'h0000_FFFF);

    // Reset landing on a mispredicting update clears everything.
    cycle(32'h1000, 1'b1, 32'h1000, 1'b1, 32'h900, 1'b0, 1'b0);
    probe(32'h1000);
    chk("mid_rst_cnt", {16'b0, bp.MispredCnt}, 32'd0);
    chk("mid_rst_hit", {31'b0, bp.PredHit}, 32'd0);
    chk("mid_rst_target", bp.PredTarget, 32'h1004);
    cycle(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 1'b1);
    probe(32'h40);
    chk("post_rst_cnt", {16'b0, bp.MispredCnt}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
